// File: rtl/uart_rx_ctrl_if.sv
// Host/receiver-facing signal bundle for uart_rx_ctrl; master drives the controls,
// slave is the controller itself.
interface uart_rx_ctrl_if #(
  parameter int DIV_W = 16,
  parameter int AW    = 3
);
  logic             rx_en;
  logic [DIV_W-1:0] baud_div;
  logic             bx8clk;
  logic [7:0]       rdr_in;
  logic             rdr_ready;
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic [AW:0]      rx_thresh;
  logic             overrun;
  logic             clr_overrun;
  logic             irq;

  modport master (
    output rx_en, baud_div, rdr_in, rdr_ready, rd_en, rx_thresh, clr_overrun,
    input  bx8clk, rd_data, empty, full, count, overrun, irq
  );

  modport slave (
    input  rx_en, baud_div, rdr_in, rdr_ready, rd_en, rx_thresh, clr_overrun,
    output bx8clk, rd_data, empty, full, count, overrun, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: 8x tick divider plus show-ahead byte FIFO with level/overrun irq.
// Define UART_RX_TIMEOUT_EN to add the 320-tick idle timeout term to irq.
module uart_rx_ctrl #(
  parameter int DIV_W = 16,
  parameter int AW    = 3
) (
  input  logic           sysclk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  bus
);
  localparam int DEPTH = 1 << AW;

  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_cnt_nxt;
  logic             bx8_q;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count_q;
  logic [AW:0]      count_nxt;
  logic             empty_q;
  logic             full_q;
  logic             overrun_q;
  logic             overrun_nxt;
  logic             irq_q;
  logic             push;
  logic             pop;
  logic             drop;
  logic             lvl;
  logic             tmo_nxt;

  // Divisors below 2 would make the tick a constant level, so clamp.
  always_comb begin
    div_eff = (bus.baud_div < DIV_W'(2)) ? DIV_W'(2) : bus.baud_div;
    div_cnt_nxt = div_eff - DIV_W'(1);
    if (bus.rx_en && (div_cnt != '0)) div_cnt_nxt = div_cnt - DIV_W'(1);
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bx8_q   <= 1'b0;
    end else begin
      div_cnt <= div_cnt_nxt;
      bx8_q   <= bus.rx_en && (div_cnt_nxt == '0);
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  always_comb begin
    pop         = bus.rd_en & ~empty_q;
    push        = bus.rdr_ready & bus.rx_en & (~full_q | pop);
    drop        = bus.rdr_ready & bus.rx_en & full_q & ~pop;
    count_nxt   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    overrun_nxt = drop | (overrun_q & ~bus.clr_overrun);
    lvl         = (bus.rx_thresh != '0) && (count_nxt >= bus.rx_thresh);
  end

  always_ff @(posedge sysclk) begin
    if (push) mem[wptr] <= bus.rdr_in;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count_q   <= count_nxt;
      empty_q   <= (count_nxt == '0);
      full_q    <= (count_nxt == (AW+1)'(DEPTH));
      overrun_q <= overrun_nxt;
      irq_q     <= overrun_nxt | lvl | tmo_nxt;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [8:0] tick_q;
  logic [8:0] tick_nxt;
  logic       tmo_q;

  // 320 ticks = 4 character times of 10 bits at 8x oversampling.
  always_comb begin
    tick_nxt = tick_q;
    if (push || pop || empty_q) tick_nxt = '0;
    else if (bx8_q && (tick_q != 9'd320)) tick_nxt = tick_q + 9'd1;
    tmo_nxt = (push || pop) ? 1'b0 : (tmo_q || (tick_nxt == 9'd320));
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tick_q <= tick_nxt;
      tmo_q  <= tmo_nxt;
    end
  end
`else
  assign tmo_nxt = 1'b0;
`endif

  assign bus.bx8clk  = bx8_q;
  assign bus.rd_data = mem[rptr];
  assign bus.empty   = empty_q;
  assign bus.full    = full_q;
  assign bus.count   = count_q;
  assign bus.overrun = overrun_q;
  assign bus.irq     = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: divider timing, FIFO order, overrun, level irq, reset.
module tb_uart_rx_ctrl;
  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysclk = ~sysclk;

  uart_rx_ctrl_if #(.DIV_W(16), .AW(3)) bus ();
  uart_rx_ctrl #(.DIV_W(16), .AW(3)) dut (.sysclk(sysclk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".count"},   32'(bus.count),   32'(sb.size()));
    chk({tag, ".empty"},   32'(bus.empty),   32'(sb.size() == 0));
    chk({tag, ".full"},    32'(bus.full),    32'(sb.size() == 8));
    chk({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
  endtask

  task automatic push_byte(input logic [7:0] b);
    if (bus.rx_en) begin
      if (sb.size() < 8) sb.push_back(b);
      else m_ovr = 1'b1;
    end
    bus.rdr_in = b;
    bus.rdr_ready = 1'b1;
    cyc();
    bus.rdr_ready = 1'b0;
  endtask

  task automatic pop_byte();
    logic [7:0] e;
    e = sb.pop_front();
    chk("rd_data", 32'(bus.rd_data), 32'(e));
    bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
  endtask

  task automatic meas(output int per);
    int n;
    per = -1;
    n = 0;
    while (bus.bx8clk !== 1'b1 && n < 100) begin cyc(); n++; end
    if (n >= 100) return;
    n = 0;
    do begin cyc(); n++; end while (bus.bx8clk !== 1'b1 && n < 100);
    per = n;
  endtask

  initial begin
    int per;
    int pulses;
    int ticks;
    int n;
    bus.rx_en = 1'b0; bus.baud_div = 16'd4; bus.rdr_in = '0; bus.rdr_ready = 1'b0;
    bus.rd_en = 1'b0; bus.rx_thresh = '0; bus.clr_overrun = 1'b0;
    repeat (3) cyc();
    chk("rst.bx8clk", 32'(bus.bx8clk), 0);
    chk("rst.irq", 32'(bus.irq), 0);
    chk_state("rst");
    rst = 1'b0;
    cyc();

    // Divider
    bus.rx_en = 1'b1;
    meas(per); chk("div4.period", per, 4);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin if (bus.bx8clk === 1'b1) pulses++; cyc(); end
    chk("div4.pulses", pulses, 10);
    bus.baud_div = 16'd0;
    meas(per); meas(per); chk("div0.period", per, 2);
    bus.baud_div = 16'd1;
    meas(per); meas(per); chk("div1.period", per, 2);
    bus.baud_div = 16'd7;
    meas(per); meas(per); chk("div7.period", per, 7);
    bus.rx_en = 1'b0;
    cyc();
    pulses = 0;
    for (int i = 0; i < 30; i++) begin if (bus.bx8clk === 1'b1) pulses++; cyc(); end
    chk("dis.pulses", pulses, 0);
    push_byte(8'h99);
    chk_state("dis.push");
    bus.rx_en = 1'b1;
    bus.baud_div = 16'd4;

    // Fill, overrun, drain
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    chk_state("fill");
    push_byte(8'hAA);
    chk_state("ovr");
    chk("ovr.irq", 32'(bus.irq), 1);
    bus.clr_overrun = 1'b1; cyc(); bus.clr_overrun = 1'b0;
    m_ovr = 1'b0;
    chk_state("clr");
    chk("clr.irq", 32'(bus.irq), 0);
    while (sb.size() > 0) pop_byte();
    chk_state("drain");
    bus.rd_en = 1'b1; cyc(); bus.rd_en = 1'b0;
    chk_state("underflow");

    // Push+pop while full: slot freed, no overrun, new byte read last
    for (int i = 0; i < 8; i++) push_byte(8'h11 + 8'(i));
    chk("pp.head", 32'(bus.rd_data), 32'(sb[0]));
    void'(sb.pop_front());
    sb.push_back(8'h55);
    bus.rdr_in = 8'h55; bus.rdr_ready = 1'b1; bus.rd_en = 1'b1;
    cyc();
    bus.rdr_ready = 1'b0; bus.rd_en = 1'b0;
    chk_state("pp.full");
    while (sb.size() > 0) pop_byte();

    // Push+pop while empty: push only
    bus.rdr_in = 8'h77; bus.rdr_ready = 1'b1; bus.rd_en = 1'b1;
    sb.push_back(8'h77);
    cyc();
    bus.rdr_ready = 1'b0; bus.rd_en = 1'b0;
    chk_state("pp.empty");
    pop_byte();

    // Level interrupt
    bus.rx_thresh = 4'd3;
    push_byte(8'hC1); chk("lvl.1", 32'(bus.irq), 0);
    push_byte(8'hC2); chk("lvl.2", 32'(bus.irq), 0);
    push_byte(8'hC3); chk("lvl.3", 32'(bus.irq), 1);
    pop_byte();       chk("lvl.pop", 32'(bus.irq), 0);
    while (sb.size() > 0) pop_byte();
    bus.rx_thresh = '0;

    // Async reset mid-divider with bytes held
    bus.baud_div = 16'd6;
    push_byte(8'hD1); push_byte(8'hD2); push_byte(8'hD3);
    cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    sb.delete();
    m_ovr = 1'b0;
    chk("arst.bx8clk", 32'(bus.bx8clk), 0);
    chk("arst.irq", 32'(bus.irq), 0);
    chk_state("arst");
    cyc();
    rst = 1'b0;
    cyc();

`ifdef UART_RX_TIMEOUT_EN
    bus.baud_div = 16'd2;
    push_byte(8'hE1);
    ticks = 0;
    n = 0;
    while (n < 1000) begin
      if (bus.irq === 1'b1) break;
      if (bus.bx8clk === 1'b1) ticks++;
      cyc();
      n++;
    end
    chk("tmo.ticks", ticks, 320);
    chk("tmo.irq", 32'(bus.irq), 1);
    pop_byte();
    chk("tmo.pop", 32'(bus.irq), 0);
`else
    bus.baud_div = 16'd2;
    push_byte(8'hE1);
    ticks = 0;
    n = 0;
    repeat (700) cyc();
    chk("notmo.irq", 32'(bus.irq), 0);
    pop_byte();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
